wb_stage_seq: RTL
=================

Name: wb_stage_seq

Overview:
Registered, parametrised writeback stage for the SPARC pipeline.
- Accepts one retiring instruction per cycle over a valid/ready handshake.
- Performs big-endian load lane extraction and sign/zero extension.
- Drives the register-file write port, Y and icc.
- Splits double-register writes (LDD, paired ALU results) into two back-to-back register-file beats over a single REGW-wide write port.

Parameters:
- REGW, 32, register-file write port width in bits.
- DATA_W, 64, load-data / ALU-result width; must equal 2*REGW.
- RADDR_W, 5, register address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  retiring instruction present.
- in_ready  out  1  stage can accept; low during second beat.
- in_alures  in  DATA_W  ALU result.
- in_load_data  in  DATA_W  aligned doubleword read from memory.
- in_addr_lo  in  3  byte offset of the load address within the doubleword.
- in_regD  in  RADDR_W  destination register.
- in_op / in_op2 / in_op3  in  2/3/6  instruction opcode fields.
- in_regWrite, in_regWriteDouble  in  1  single / double register write request.
- in_Y_write, in_icc_write  in  1  Y / icc update request.
- in_icc  in  4  new condition codes.
- reg_en  out  1  register-file write enable.
- reg_addr  out  RADDR_W  write address.
- reg_data  out  REGW  write data.
- Y_en  out  1  Y write enable.
- Y_data  out  REGW  in_alures[DATA_W-1:REGW].
- icc_en  out  1  icc write enable.
- icc_out  out  4  condition codes.

Behaviour:
Reset and handshake
- reset: state IDLE. All outputs 0. in_ready=1 on the cycle after reset.
- Accept occurs when in_valid && in_ready.
- All outputs are registered: beat 1 appears the cycle after accept (latency 1). No downstream backpressure.

NOP suppression
- A NOP is op=00, op2=100, regD=0.
- An accepted NOP produces all enables 0 and all data outputs 0, matching the no-accept cycle.

Load extraction (op=11)
- Byte offset a = in_addr_lo.
- LDSB/LDUB: byte in_load_data[63-8a -: 8], sign- / zero-extended to REGW.
- LDSH/LDUH: in_load_data[63-8a' -: 16], where a' = a with bit0 cleared; sign- / zero-extended.
- LD: in_load_data[63-8a'' -: 32], where a'' = a with bits[1:0] cleared.
- LDD: beat 1 data = [63:32], beat 2 data = [31:0]. a is ignored.
- Misalignment is not checked; traps are raised upstream.
- Any other op3 with op=11: reg_data = in_alures[REGW-1:0].

Non-load writes
- reg_data = in_alures[REGW-1:0].
- With in_regWriteDouble=1: beat 1 = in_alures[DATA_W-1:REGW], beat 2 = in_alures[REGW-1:0].

Double write (LDD, or in_regWriteDouble=1)
- Beat 1: reg_addr = regD with bit0 cleared.
- Beat 2: reg_addr = regD with bit0 set.
- FSM: IDLE → (accept && double) → BEAT2. BEAT2 → IDLE unconditionally next cycle.
- In BEAT2, in_ready=0; in_valid is ignored and not accepted.

Per-beat rules
- reg_en = request && (reg_addr != 0). Writes to r0 are always suppressed per beat; LDD to r0 still writes r1 in beat 2.
- Y_en and icc_en are asserted on beat 1 only; 0 on beat 2.
- Y_data and icc_out are held during beat 2.
- Back-to-back single writes: one per cycle, no bubbles.

Reset mid-operation
- Reset asserted while in BEAT2 → IDLE. The beat-2 write is dropped and all enables are 0 on the following cycle.

Decomposition:
- Package wb_pkg holds:
  - op3 constants LD=000000, LDUB=000001, LDUH=000010, LDD=000011, LDSB=001001, LDSH=001010.
  - Enum wb_state_t {IDLE, BEAT2}.
  - Functions is_load_op and is_nop.
- One sub-module, wb_load_align: combinational lane select and extension (in_load_data, addr_lo, op3 → 2×REGW result).
- FSM, registers and handshake live in wb_stage_seq.

Test Plan:
- Reset held 2 cycles, then released → all outputs 0, in_ready=1, no reg_en pulses.
- LDSB, addr_lo=3, data=0x0000_0080_0000_0000, regD=4 → next cycle: reg_en=1, addr=4, data=0xFFFF_FF80.
- LDUH, addr_lo=6, data=0x0000_0000_0000_BEEF → data=0x0000_BEEF.
- LDD, regD=9, data=0x1111_2222_3333_4444:
  - cycle+1: addr=8, data=0x1111_2222, in_ready=0.
  - cycle+2: addr=9, data=0x3333_4444.
  - A concurrent in_valid is not accepted until cycle+2.
- ALU single write to regD=0 with icc_write=1, icc=0xA → reg_en=0, icc_en=1, icc_out=0xA. A following NOP → all enables 0.
- LDD accepted, reset asserted during BEAT2 → no beat-2 write, state IDLE, in_ready=1 after reset.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: opcode constants, FSM state type and decode helpers for the writeback stage.
package wb_pkg;
  localparam logic [5:0] OP3_LD   = 6'b000000;
  localparam logic [5:0] OP3_LDUB = 6'b000001;
  localparam logic [5:0] OP3_LDUH = 6'b000010;
  localparam logic [5:0] OP3_LDD  = 6'b000011;
  localparam logic [5:0] OP3_LDSB = 6'b001001;
  localparam logic [5:0] OP3_LDSH = 6'b001010;
  typedef enum logic {IDLE, BEAT2} wb_state_t;
  function automatic logic is_load_op(input logic [1:0] op, input logic [5:0] op3);
    return op == 2'b11 && (op3 inside {OP3_LD, OP3_LDUB, OP3_LDUH, OP3_LDD, OP3_LDSB, OP3_LDSH});
  endfunction
  function automatic logic is_nop(input logic [1:0] op, input logic [2:0] op2, input logic rd_zero);
    return op == 2'b00 && op2 == 3'b100 && rd_zero;
  endfunction
endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: big-endian load lane select and sign/zero extension; {beat1, beat2} for LDD.
module wb_load_align import wb_pkg::*; #(
  parameter int REGW   = 32,
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] data,
  input  logic [2:0]        addr_lo,
  input  logic [5:0]        op3,
  output logic [DATA_W-1:0] res
);
  logic [5:0] sh_b, sh_h, sh_w;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] w;
  assign sh_b = 6'd56 - {addr_lo, 3'b000};
  assign sh_h = 6'd48 - {addr_lo[2:1], 4'b0000};
  assign sh_w = 6'd32 - {addr_lo[2], 5'b00000};
  assign b = data[sh_b +: 8];
  assign h = data[sh_h +: 16];
  assign w = data[sh_w +: 32];
  always_comb
    res = op3 == OP3_LDSB ? {{REGW{1'b0}}, {(REGW-8){b[7]}}, b} :
          op3 == OP3_LDUB ? {{REGW{1'b0}}, {(REGW-8){1'b0}}, b} :
          op3 == OP3_LDSH ? {{REGW{1'b0}}, {(REGW-16){h[15]}}, h} :
          op3 == OP3_LDUH ? {{REGW{1'b0}}, {(REGW-16){1'b0}}, h} :
          op3 == OP3_LD   ? {{REGW{1'b0}}, w} : data;
endmodule

// File: rtl/wb_stage_seq.sv
// wb_stage_seq: registered writeback stage; splits double writes into two register-file beats.
module wb_stage_seq import wb_pkg::*; #(
  parameter int REGW    = 32,
  parameter int DATA_W  = 64,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_alures,
  input  logic [DATA_W-1:0]  in_load_data,
  input  logic [2:0]         in_addr_lo,
  input  logic [RADDR_W-1:0] in_regD,
  input  logic [1:0]         in_op,
  input  logic [2:0]         in_op2,
  input  logic [5:0]         in_op3,
  input  logic               in_regWrite,
  input  logic               in_regWriteDouble,
  input  logic               in_Y_write,
  input  logic               in_icc_write,
  input  logic [3:0]         in_icc,
  output logic               reg_en,
  output logic [RADDR_W-1:0] reg_addr,
  output logic [REGW-1:0]    reg_data,
  output logic               Y_en,
  output logic [REGW-1:0]    Y_data,
  output logic               icc_en,
  output logic [3:0]         icc_out
);
  wb_state_t state_q, state_d;
  logic reg_en_q, reg_en_d, y_en_q, y_en_d, icc_en_q, icc_en_d, b2_en_q, b2_en_d;
  logic [RADDR_W-1:0] reg_addr_q, reg_addr_d, b2_addr_q, b2_addr_d, addr1;
  logic [REGW-1:0] reg_data_q, reg_data_d, y_data_q, y_data_d, b2_data_q, b2_data_d;
  logic [3:0] icc_q, icc_d;
  logic [DATA_W-1:0] al_res, res;
  logic ld, dbl, req, act;
  wb_load_align #(.REGW(REGW), .DATA_W(DATA_W)) u_align (
    .data(in_load_data), .addr_lo(in_addr_lo), .op3(in_op3), .res(al_res)
  );
  assign in_ready = state_q == IDLE;
  assign ld = is_load_op(in_op, in_op3);
  assign res = ld ? al_res : in_alures;
  assign dbl = (ld && in_op3 == OP3_LDD) || in_regWriteDouble;
  assign req = in_regWrite || in_regWriteDouble;
  assign act = in_valid && in_ready && !is_nop(in_op, in_op2, in_regD == '0);
  assign addr1 = dbl ? {in_regD[RADDR_W-1:1], 1'b0} : in_regD;
  // Beat 2 replays the captured low half; Y/icc data hold but their enables drop.
  always_comb begin
    state_d = IDLE;
    reg_en_d = 1'b0;
    reg_addr_d = '0;
    reg_data_d = '0;
    y_en_d = 1'b0;
    y_data_d = '0;
    icc_en_d = 1'b0;
    icc_d = '0;
    b2_en_d = 1'b0;
    b2_addr_d = '0;
    b2_data_d = '0;
    if (state_q == BEAT2) begin
      reg_en_d = b2_en_q;
      reg_addr_d = b2_addr_q;
      reg_data_d = b2_data_q;
      y_data_d = y_data_q;
      icc_d = icc_q;
    end else if (act) begin
      state_d = dbl ? BEAT2 : IDLE;
      reg_addr_d = addr1;
      reg_data_d = dbl ? res[DATA_W-1:REGW] : res[REGW-1:0];
      reg_en_d = req && addr1 != '0;
      y_en_d = in_Y_write;
      y_data_d = in_alures[DATA_W-1:REGW];
      icc_en_d = in_icc_write;
      icc_d = in_icc;
      b2_en_d = req && dbl;
      b2_addr_d = {in_regD[RADDR_W-1:1], 1'b1};
      b2_data_d = res[REGW-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      reg_en_q <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      y_en_q <= 1'b0;
      y_data_q <= '0;
      icc_en_q <= 1'b0;
      icc_q <= '0;
      b2_en_q <= 1'b0;
      b2_addr_q <= '0;
      b2_data_q <= '0;
    end else begin
      state_q <= state_d;
      reg_en_q <= reg_en_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      y_en_q <= y_en_d;
      y_data_q <= y_data_d;
      icc_en_q <= icc_en_d;
      icc_q <= icc_d;
      b2_en_q <= b2_en_d;
      b2_addr_q <= b2_addr_d;
      b2_data_q <= b2_data_d;
    end
  end
  assign reg_en = reg_en_q;
  assign reg_addr = reg_addr_q;
  assign reg_data = reg_data_q;
  assign Y_en = y_en_q;
  assign Y_data = y_data_q;
  assign icc_en = icc_en_q;
  assign icc_out = icc_q;
endmodule
